// File: rtl/mire_pkg.sv
// Shared types and pattern helper for the mire test-pattern writer.
package mire_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  // White on grid lines (pitch is a power of two) and on the right/bottom border.
  function automatic logic [23:0] grid_pixel(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned hdisp,
                                             input int unsigned vdisp,
                                             input int unsigned grid);
    logic on_grid;
    on_grid = ((x & (grid - 1)) == 0) || ((y & (grid - 1)) == 0) ||
              (x == hdisp - 1) || (y == vdisp - 1);
    return on_grid ? WHITE : BLACK;
  endfunction

endpackage

// File: rtl/mire_pattern.sv
// Pixel position counters and registered grid colour, advanced one pixel per step.
module mire_pattern
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int GRID  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [23:0] rgb,
  output logic        last_pixel
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);

  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;

  // The last pixel of the frame wraps both counters back to the origin.
  always_comb begin
    x_nxt = x + 1'b1;
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
    end
  end

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      rgb <= WHITE;
    end else if (step) begin
      x   <= x_nxt;
      y   <= y_nxt;
      rgb <= grid_pixel(32'(x_nxt), 32'(y_nxt), HDISP, VDISP, GRID);
    end
  end

endmodule

// File: rtl/mire_writer.sv
// Wishbone write master filling the framebuffer with a grid pattern,
// releasing the bus after every burst and at the end of each frame.
module mire_writer
  import mire_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int          BURST_LEN = 64,
  parameter int          GRID      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic [3:0]  sel,
  output logic        we,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  output logic        stb,
  output logic        cyc,
  input  logic        ack,
  output logic        busy,
  output logic        frame_done
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic          step;
  logic          last_pixel;
  logic [23:0]   rgb;

  assign sel    = 4'b1111;
  assign we     = 1'b1;
  assign cti    = 3'b000;
  assign bte    = 2'b00;
  assign dat_ms = {8'h00, rgb};
  assign step   = stb && ack;

  mire_pattern #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .GRID  (GRID)
  ) u_pattern (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .rgb        (rgb),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= 1'b0;
      stb        <= 1'b0;
      adr        <= BASE_ADR;
      burst_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= WRITE;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        WRITE: begin
          if (ack) begin
            if (last_pixel) begin
              // Frame end always closes the tenure, however short the burst.
              frame_done <= 1'b1;
              adr        <= BASE_ADR;
              burst_cnt  <= '0;
              cyc        <= 1'b0;
              stb        <= 1'b0;
              if (enable) begin
                state <= RELEASE;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              adr <= adr + 32'd4;
              if (burst_cnt == B_LAST) begin
                burst_cnt <= '0;
                state     <= RELEASE;
                cyc       <= 1'b0;
                stb       <= 1'b0;
              end else begin
                burst_cnt <= burst_cnt + 1'b1;
              end
            end
          end
        end
        RELEASE: begin
          state <= WRITE;
          cyc   <= 1'b1;
          stb   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          cyc   <= 1'b0;
          stb   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mire_writer.sv
// Directed self-checking bench for mire_writer (800x9 frame keeps runs short).
module tb_mire_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic        we, stb, cyc, busy, frame_done;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int n_checks = 0;
  int n_fail   = 0;
  int acked;

  localparam logic [31:0] W = 32'h00FFFFFF;
  localparam logic [31:0] K = 32'h00000000;

  mire_writer #(
    .HDISP     (800),
    .VDISP     (9),
    .BASE_ADR  (32'h0000_0000),
    .BURST_LEN (64),
    .GRID      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .adr        (adr),
    .dat_ms     (dat_ms),
    .sel        (sel),
    .we         (we),
    .cti        (cti),
    .bte        (bte),
    .stb        (stb),
    .cyc        (cyc),
    .ack        (ack),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Number of writes accepted since reset; write #N is the one presented when acked==N.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acked <= 0;
    else if (stb && ack) acked <= acked + 1;
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    ack    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_write(input int n, input int budget, input string name);
    int c = 0;
    while (!(stb === 1'b1 && acked == n) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL %s: write #%0d not presented within %0d cycles (acked=%0d)", name, n, budget, acked);
    end
  endtask

  task automatic test_reset();
    int c = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cyc !== 1'b0) begin n_fail++; $display("FAIL rst_cyc: got %b want 0", cyc); end
    n_checks++; if (stb !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b want 0", stb); end
    n_checks++; if (adr !== 32'd0) begin n_fail++; $display("FAIL rst_adr: got %h want 0", adr); end
    n_checks++; if (dat_ms !== W) begin n_fail++; $display("FAIL rst_dat: got %h want %h", dat_ms, W); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", frame_done); end
    n_checks++; if ({sel, we, cti, bte} !== {4'hF, 1'b1, 3'b000, 2'b00}) begin n_fail++; $display("FAIL rst_const: got %b want 1111_1_000_00", {sel, we, cti, bte}); end
    enable = 1'b1;
    rst_n  = 1'b1;
    while (cyc !== 1'b1 && c < 4) begin
      @(negedge clk);
      c++;
    end
    n_checks++; if (c < 1 || c > 2) begin n_fail++; $display("FAIL rst_start: cyc after %0d cycles want 1..2", c); end
    n_checks++; if (stb !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_start_stb: stb=%b busy=%b want 1 1", stb, busy); end
  endtask

  task automatic test_pattern();
    do_reset();
    enable = 1'b1;
    ack    = 1'b1;
    wait_write(0, 10, "pat_w0");
    n_checks++; if (adr !== 32'd0 || dat_ms !== W) begin n_fail++; $display("FAIL pat_w0: got adr=%0d dat=%h want 0 %h", adr, dat_ms, W); end
    wait_write(1, 10, "pat_w1");
    n_checks++; if (adr !== 32'd4 || dat_ms !== W) begin n_fail++; $display("FAIL pat_w1: got adr=%0d dat=%h want 4 %h", adr, dat_ms, W); end
    wait_write(16, 30, "pat_w16");
    n_checks++; if (adr !== 32'd64 || dat_ms !== W) begin n_fail++; $display("FAIL pat_w16: got adr=%0d dat=%h want 64 %h", adr, dat_ms, W); end
    wait_write(799, 900, "pat_w799");
    n_checks++; if (adr !== 32'd3196 || dat_ms !== W) begin n_fail++; $display("FAIL pat_w799: got adr=%0d dat=%h want 3196 %h", adr, dat_ms, W); end
    wait_write(800, 10, "pat_w800");
    n_checks++; if (adr !== 32'd3200 || dat_ms !== W) begin n_fail++; $display("FAIL pat_w800: got adr=%0d dat=%h want 3200 %h", adr, dat_ms, W); end
    wait_write(801, 10, "pat_w801");
    n_checks++; if (adr !== 32'd3204 || dat_ms !== K) begin n_fail++; $display("FAIL pat_w801: got adr=%0d dat=%h want 3204 %h", adr, dat_ms, K); end
    wait_write(816, 30, "pat_w816");
    n_checks++; if (adr !== 32'd3264 || dat_ms !== W) begin n_fail++; $display("FAIL pat_w816: got adr=%0d dat=%h want 3264 %h", adr, dat_ms, W); end
    wait_write(817, 10, "pat_w817");
    n_checks++; if (adr !== 32'd3268 || dat_ms !== K) begin n_fail++; $display("FAIL pat_w817: got adr=%0d dat=%h want 3268 %h", adr, dat_ms, K); end
  endtask

  task automatic test_ack_stall();
    do_reset();
    enable = 1'b1;
    ack    = 1'b1;
    wait_write(5, 20, "stall_w5");
    ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (adr !== 32'd20 || dat_ms !== W || stb !== 1'b1 || cyc !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got adr=%0d dat=%h stb=%b cyc=%b want 20 %h 1 1", i, adr, dat_ms, stb, cyc, W); end
    end
    ack = 1'b1;
    @(negedge clk);
    n_checks++; if (acked !== 6 || adr !== 32'd24) begin n_fail++; $display("FAIL stall_done: got acked=%0d adr=%0d want 6 24", acked, adr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    ack    = 1'b1;
    wait_write(0, 10, "b2b_w0");
    repeat (10) @(negedge clk);
    n_checks++; if (acked !== 10 || adr !== 32'd40) begin n_fail++; $display("FAIL b2b_rate: got acked=%0d adr=%0d want 10 40", acked, adr); end
    wait_write(63, 80, "burst_w63");
    @(negedge clk);
    n_checks++; if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL burst1_gap: got cyc=%b stb=%b busy=%b want 0 0 1", cyc, stb, busy); end
    @(negedge clk);
    n_checks++; if (cyc !== 1'b1 || adr !== 32'd256 || acked !== 64) begin n_fail++; $display("FAIL burst1_resume: got cyc=%b adr=%0d acked=%0d want 1 256 64", cyc, adr, acked); end
    wait_write(127, 80, "burst_w127");
    @(negedge clk);
    n_checks++; if (cyc !== 1'b0) begin n_fail++; $display("FAIL burst2_gap: got cyc=%b want 0", cyc); end
    @(negedge clk);
    n_checks++; if (cyc !== 1'b1 || adr !== 32'd512) begin n_fail++; $display("FAIL burst2_resume: got cyc=%b adr=%0d want 1 512", cyc, adr); end
  endtask

  task automatic test_frame_end();
    int stb_seen = 0;
    int c = 0;
    do_reset();
    enable = 1'b1;
    ack    = 1'b1;
    wait_write(7199, 8000, "frame1_last");
    n_checks++; if (adr !== 32'd28796 || dat_ms !== W || frame_done !== 1'b0) begin n_fail++; $display("FAIL frame1_last: got adr=%0d dat=%h done=%b want 28796 %h 0", adr, dat_ms, frame_done, W); end
    @(negedge clk);
    n_checks++; if (frame_done !== 1'b1 || cyc !== 1'b0 || busy !== 1'b1 || adr !== 32'd0 || dat_ms !== W) begin n_fail++; $display("FAIL frame1_end: got done=%b cyc=%b busy=%b adr=%0d dat=%h want 1 0 1 0 %h", frame_done, cyc, busy, adr, dat_ms, W); end
    enable = 1'b0;
    @(negedge clk);
    n_checks++; if (frame_done !== 1'b0 || cyc !== 1'b1 || adr !== 32'd0) begin n_fail++; $display("FAIL frame2_start: got done=%b cyc=%b adr=%0d want 0 1 0", frame_done, cyc, adr); end
    wait_write(14399, 8000, "frame2_last");
    n_checks++; if (adr !== 32'd28796 || busy !== 1'b1) begin n_fail++; $display("FAIL frame2_last: got adr=%0d busy=%b want 28796 1", adr, busy); end
    @(negedge clk);
    n_checks++; if (frame_done !== 1'b1 || busy !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0) begin n_fail++; $display("FAIL frame2_idle: got done=%b busy=%b cyc=%b stb=%b want 1 0 0 0", frame_done, busy, cyc, stb); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb !== 1'b0) stb_seen++;
    end
    n_checks++; if (stb_seen !== 0 || adr !== 32'd0) begin n_fail++; $display("FAIL idle_quiet: got stb_cycles=%0d adr=%0d want 0 0", stb_seen, adr); end
    enable = 1'b1;
    while (stb !== 1'b1 && c < 4) begin
      @(negedge clk);
      c++;
    end
    n_checks++; if (c < 1 || c > 2 || adr !== 32'd0 || dat_ms !== W) begin n_fail++; $display("FAIL restart: got cycles=%0d adr=%0d dat=%h want 1..2 0 %h", c, adr, dat_ms, W); end
  endtask

  task automatic test_midframe_reset();
    int done_seen = 0;
    do_reset();
    enable = 1'b1;
    ack    = 1'b1;
    wait_write(1000, 1200, "mid_w1000");
    n_checks++; if (adr !== 32'd4000) begin n_fail++; $display("FAIL mid_w1000: got adr=%0d want 4000", adr); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (cyc !== 1'b0 || stb !== 1'b0 || adr !== 32'd0 || busy !== 1'b0 || dat_ms !== W) begin n_fail++; $display("FAIL mid_async: got cyc=%b stb=%b adr=%0d busy=%b dat=%h want 0 0 0 0 %h", cyc, stb, adr, busy, dat_ms, W); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_write(0, 5, "mid_restart");
    n_checks++; if (adr !== 32'd0 || dat_ms !== W || frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_restart: got adr=%0d dat=%h done=%b want 0 %h 0", adr, dat_ms, frame_done, W); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) done_seen++;
    end
    n_checks++; if (done_seen !== 0 || adr !== 32'd32) begin n_fail++; $display("FAIL mid_no_done: got done_cycles=%0d adr=%0d want 0 32", done_seen, adr); end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_ack_stall();
    test_back_to_back();
    test_frame_end();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
